bus_sync_tx_ctrl: RTL and testbench



---
 rtl/bus_sync_pkg.sv | 8 +
 rtl/bit_sync.sv | 27 ++
 rtl/bus_sync_tx_ctrl.sv | 132 +++++++++++++
 tb/tb_bus_sync_tx_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sync_pkg.sv
// Shared types and constants for the bus_sync toggle-handshake source controller.
package bus_sync_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} bus_sync_tx_state_e;

  localparam int unsigned MIN_NUMSTGS = 2;

endpackage

// File: rtl/bit_sync.sv
// NUMSTGS-deep single-bit synchronizer; depth is clamped to MIN_NUMSTGS.
module bit_sync
  import bus_sync_pkg::*;
#(
  parameter int unsigned NUMSTGS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam int unsigned STG = (NUMSTGS < MIN_NUMSTGS) ? MIN_NUMSTGS : NUMSTGS;

  logic [STG-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STG-2:0], i_d};
    end
  end

  assign o_q = r_sync[STG-1];

endmodule

// File: rtl/bus_sync_tx_ctrl.sv
// Source-side 2-phase req/ack controller holding a stable bus for a bus synchronizer.
// Optional watchdog enabled by defining BUS_SYNC_TIMEOUT_EN.
module bus_sync_tx_ctrl
  import bus_sync_pkg::*;
#(
  parameter int unsigned DATAWTH     = 8,
  parameter int unsigned NUMSTGS     = 2,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [DATAWTH-1:0] src_data,
  output logic [DATAWTH-1:0] xfer_data,
  output logic               xfer_req,
  input  logic               xfer_ack_async,
  output logic               done,
  output logic               err_timeout,
  input  logic               err_clr
);

  localparam int unsigned CNTW = (SETUP_CYC > 0) ? $clog2(SETUP_CYC + 1) : 1;

  bus_sync_tx_state_e r_state;
  logic [CNTW-1:0]    r_cnt;
  logic [DATAWTH-1:0] r_data;
  logic               r_req;
  logic               r_done;
  logic               r_live;
  logic               w_ack_s;
  logic               w_accept;

  bit_sync #(.NUMSTGS(NUMSTGS)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (xfer_ack_async),
    .o_q   (w_ack_s)
  );

  // r_live keeps src_ready low while in reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  assign src_ready = r_live && (r_state == IDLE);
  assign w_accept  = src_valid && src_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data <= src_data;
            if (SETUP_CYC == 0) begin
              r_req   <= ~r_req;
              r_state <= WAIT_ACK;
            end else begin
              r_cnt   <= CNTW'(SETUP_CYC - 1);
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_req   <= ~r_req;
            r_state <= WAIT_ACK;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        WAIT_ACK: begin
          if (w_ack_s == r_req) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign xfer_data = r_data;
  assign xfer_req  = r_req;
  assign done      = r_done;

`ifdef BUS_SYNC_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] r_wdog;
  logic           r_err;

  // Leaving WAIT_ACK always passes through IDLE/SETUP, so clearing outside WAIT_ACK
  // is the same as clearing on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != WAIT_ACK) begin
        r_wdog <= '0;
      end else if (r_wdog != WDW'(TIMEOUT_CYC)) begin
        r_wdog <= r_wdog + WDW'(1);
      end
      if ((r_state == WAIT_ACK) && (r_wdog == WDW'(TIMEOUT_CYC - 1))) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err_timeout = r_err;
`else
  logic w_unused;
  assign w_unused    = err_clr & (TIMEOUT_CYC != 0);
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sync_tx_ctrl.sv
// Randomized self-checking bench for bus_sync_tx_ctrl (SETUP_CYC=2 and SETUP_CYC=0 instances).
module tb_bus_sync_tx_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned NS  = 2;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]         v, ack, eclr, rdy, req, dn, er;
  logic [1:0][DW-1:0] d, xd;

  logic [1:0]         exp_req;
  logic [1:0][DW-1:0] exp_xd;
  logic [1:0]         exp_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  bus_sync_tx_ctrl #(.DATAWTH(DW), .NUMSTGS(NS), .SETUP_CYC(2), .TIMEOUT_CYC(TMO)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .src_valid(v[0]), .src_ready(rdy[0]), .src_data(d[0]),
    .xfer_data(xd[0]), .xfer_req(req[0]), .xfer_ack_async(ack[0]), .done(dn[0]),
    .err_timeout(er[0]), .err_clr(eclr[0])
  );

  bus_sync_tx_ctrl #(.DATAWTH(DW), .NUMSTGS(NS), .SETUP_CYC(0), .TIMEOUT_CYC(TMO)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .src_valid(v[1]), .src_ready(rdy[1]), .src_data(d[1]),
    .xfer_data(xd[1]), .xfer_req(req[1]), .xfer_ack_async(ack[1]), .done(dn[1]),
    .err_timeout(er[1]), .err_clr(eclr[1])
  );

  function automatic int unsigned setup_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; v = '0; ack = '0; eclr = '0; d = '0;
    exp_req = '0; exp_xd = '0; exp_err = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  // One transfer: timing predicted from the handshake rules, not from DUT state.
  // Accept edge is c=0; req flips at c=setup; ack driven after sample c=setup+dly
  // is seen NS edges later and completes on the edge after that.
  task automatic run_xfer(input int i, input logic [DW-1:0] w, input int unsigned dly);
    int unsigned su, n;
    logic [11:0] got, want;
    su = setup_of(i);
    n  = su + dly + NS + 1;
    @(negedge clk);
    v[i] = 1'b1;
    d[i] = w;
    total++;
    if (rdy[i] !== 1'b1) begin
      bad++;
      $display("FAIL ready_idle[%0d] got=%b want=1", i, rdy[i]);
    end
    for (int c = 0; c <= int'(n); c++) begin
      @(posedge clk);
      #1;
      if (c == 0) exp_xd[i] = w;
      if (c == int'(su)) exp_req[i] = ~exp_req[i];
      got  = {rdy[i], dn[i], req[i], er[i], xd[i]};
      want = {(c == int'(n)), (c == int'(n)), exp_req[i], exp_err[i], exp_xd[i]};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL xfer[%0d] c=%0d rdy/done/req/err/data got=%h want=%h", i, c, got, want);
      end
      if (c == int'(su + dly)) ack[i] = exp_req[i];
      if (c < int'(n)) begin
        v[i] = 1'($urandom_range(0, 1));
        d[i] = DW'($urandom);
      end else begin
        v[i] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({rdy[i], dn[i], req[i], er[i], xd[i]} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outs[%0d] got=%h want=000", i, {rdy[i], dn[i], req[i], er[i], xd[i]});
      end
    end
    v = '0; ack = '0; eclr = '0; d = '0;
    exp_req = '0; exp_xd = '0; exp_err = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (rdy !== 2'b00) begin
      bad++;
      $display("FAIL ready_at_release got=%b want=00", rdy);
    end
    @(posedge clk);
    #1;
    total++;
    if ({rdy, req, dn} !== 6'b110000) begin
      bad++;
      $display("FAIL ready_after_release rdy/req/done got=%b want=110000", {rdy, req, dn});
    end
  endtask

  task automatic test_single();
    run_xfer(0, 8'hA5, 1);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_xfer(0, 8'h01, $urandom_range(0, 4));
    run_xfer(0, 8'h02, $urandom_range(0, 4));
    run_xfer(0, 8'h03, $urandom_range(0, 4));
  endtask

  task automatic test_setup0();
    for (int k = 0; k < 4; k++) run_xfer(1, DW'($urandom), $urandom_range(0, 6));
  endtask

  task automatic test_random_mix();
    for (int k = 0; k < 8; k++) run_xfer(int'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 8));
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'h3C;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req[0], xd[0]} !== 9'h13C) begin
      bad++;
      $display("FAIL mid_wait_ack req/data got=%h want=13c", {req[0], xd[0]});
    end
    @(negedge clk);
    rst_n = 1'b0;
    ack = '0;
    #1;
    total++;
    if ({rdy[0], dn[0], req[0], er[0], xd[0]} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_outs got=%h want=000", {rdy[0], dn[0], req[0], er[0], xd[0]});
    end
    exp_req = '0; exp_xd = '0; exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      total++;
      if ({dn[0], req[0], rdy[0]} !== 3'b001) begin
        bad++;
        $display("FAIL reset_mid_after c=%0d done/req/rdy got=%b want=001", c, {dn[0], req[0], rdy[0]});
      end
    end
  endtask

`ifdef BUS_SYNC_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    @(negedge clk);
    v[0] = 1'b1;
    d[0] = 8'h5A;
    eclr[0] = 1'b1;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    // WAIT_ACK entered 2 edges after accept; 16th WAIT_ACK edge is c=18. Clear held: set wins.
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (er[0] !== (c >= 18)) begin
        bad++;
        $display("FAIL timeout_set c=%0d got=%b want=%b", c, er[0], (c >= 18));
      end
    end
    eclr[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({er[0], dn[0], req[0]} !== 3'b101) begin
      bad++;
      $display("FAIL timeout_sticky err/done/req got=%b want=101", {er[0], dn[0], req[0]});
    end
    ack[0] = 1'b1;
    for (int c = 1; c <= int'(NS) + 1; c++) begin
      @(posedge clk);
      #1;
      total++;
      if ({dn[0], er[0]} !== {(c == int'(NS) + 1), 1'b1}) begin
        bad++;
        $display("FAIL late_ack c=%0d done/err got=%b want=%b", c, {dn[0], er[0]}, {(c == int'(NS) + 1), 1'b1});
      end
    end
    @(negedge clk);
    eclr[0] = 1'b1;
    @(posedge clk);
    #1;
    eclr[0] = 1'b0;
    total++;
    if (er[0] !== 1'b0) begin
      bad++;
      $display("FAIL err_clr got=%b want=0", er[0]);
    end
    exp_req[0] = 1'b1;
    exp_xd[0]  = 8'h5A;
    run_xfer(0, DW'($urandom), 2);
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    eclr = 2'b11;
    run_xfer(0, DW'($urandom), 20);
    run_xfer(1, DW'($urandom), 20);
    eclr = '0;
  endtask
`endif

  initial begin
    v = '0; ack = '0; eclr = '0; d = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_setup0();
    test_random_mix();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
